// File: rtl/sprite_write_arbiter_pkg.sv
// Shared definitions for the sprite write arbiter: FSM encoding and
// sprite-word field layout.
package sprite_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam int SPR_ACTIVE_MSB = 31;
    localparam int SPR_ACTIVE_LSB = 29;
    localparam int SPR_X_MSB      = 28;
    localparam int SPR_X_LSB      = 19;
    localparam int SPR_Y_MSB      = 18;
    localparam int SPR_Y_LSB      = 9;
    localparam int SPR_OFF_MSB    = 8;
    localparam int SPR_OFF_LSB    = 0;

    // Assemble a sprite word from its fields.
    function automatic logic [31:0] sprite_word(
        input logic [2:0] active,
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [8:0] offset
    );
        return {active, x, y, offset};
    endfunction

endpackage

// File: rtl/sprite_write_arbiter_rr_select.sv
// Round-robin selector: picks the first set request after i_last,
// wrapping modulo NUM_REQ.
module rr_select
    import sprite_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    logic             w_hit;

    function automatic logic [IDX_W-1:0] wrap_idx(
        input logic [IDX_W-1:0] base,
        input int               k
    );
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return s[IDX_W-1:0];
    endfunction

    // Scan from i_last+1 onward; the first hit wins.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        w_hit    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx    = wrap_idx(i_last, k);
            w_hit    = i_req[w_idx] & ~w_found;
            o_winner = w_hit ? w_idx : o_winner;
            w_found  = w_found | w_hit;
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/sprite_write_arbiter.sv
// Arbitrates sprite-word writes into the register bank during vertical
// blanking, suppressing writes of words already held in the bank.
module sprite_write_arbiter
    import sprite_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 5,
    parameter int SLOT_BASE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vblank,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] data_in,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     r_win;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_wr_en;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [31:0]          r_wr_data;
    logic                 r_busy;
    logic [31:0]          r_shadow [NUM_REQ];
    logic [NUM_REQ-1:0]   r_valid;

    logic [IDX_W-1:0]     w_winner;
    logic                 w_any;
    logic [31:0]          w_word;
    logic                 w_skip;
    logic                 w_take;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic                 w_wr_en_nxt;
    logic [ADDR_W-1:0]    w_addr_nxt;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .i_req    (req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_word     = data_in[32*w_winner +: 32];
    assign w_skip     = r_valid[w_winner] & (r_shadow[w_winner] == w_word);
    assign w_addr_nxt = ADDR_W'(SLOT_BASE + int'(w_winner));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; WRITE always returns through SCAN.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_state_nxt = vblank ? ST_SCAN : ST_IDLE;
            ST_SCAN: begin
                if (!vblank) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_any) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_WRITE: w_state_nxt = ST_SCAN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: next-cycle grant/strobe, registered below so they
    // coincide with the WRITE state.
    always_comb begin
        w_take      = (r_state == ST_SCAN) & vblank & w_any;
        w_grant_nxt = w_take ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner) : '0;
        w_wr_en_nxt = w_take & ~w_skip;
    end

    // Output and arbitration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 32'd0;
            r_busy    <= 1'b0;
            r_last    <= IDX_W'(NUM_REQ - 1);
            r_win     <= '0;
            r_valid   <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_wr_en <= w_wr_en_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_take) begin
                r_wr_addr <= w_addr_nxt;
                r_wr_data <= w_word;
                r_last    <= w_winner;
                r_win     <= w_winner;
            end else begin
                r_wr_addr <= r_wr_addr;
                r_wr_data <= r_wr_data;
                r_last    <= r_last;
                r_win     <= r_win;
            end
            if ((r_state == ST_WRITE) && r_wr_en) begin
                r_valid[r_win] <= 1'b1;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    // Shadow copies of bank contents; validity is tracked by r_valid.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == ST_WRITE) && r_wr_en) begin
            r_shadow[r_win] <= r_wr_data;
        end else begin
            r_shadow[r_win] <= r_shadow[r_win];
        end
    end

    assign grant   = r_grant;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;

endmodule

// File: tb/tb_sprite_write_arbiter.sv
// Directed bench for sprite_write_arbiter: reset, vblank gating, round-robin
// order, duplicate-word suppression, vblank fall, mid-write reset, address wrap.
module tb_sprite_write_arbiter;
    import sprite_write_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         vblank;
    logic [3:0]   req;
    logic [127:0] data_in;
    logic [3:0]   grant, grant_w;
    logic         wr_en, wr_en_w;
    logic [4:0]   wr_addr, wr_addr_w;
    logic [31:0]  wr_data, wr_data_w;
    logic         busy, busy_w;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] d [4];

    sprite_write_arbiter #(.NUM_REQ(4), .ADDR_W(5), .SLOT_BASE(0)) dut (
        .clk(clk), .reset(reset), .vblank(vblank), .req(req), .data_in(data_in),
        .grant(grant), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    sprite_write_arbiter #(.NUM_REQ(4), .ADDR_W(5), .SLOT_BASE(30)) dut_wrap (
        .clk(clk), .reset(reset), .vblank(vblank), .req(req), .data_in(data_in),
        .grant(grant_w), .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w), .busy(busy_w)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset   = 1'b1;
        vblank  = 1'b0;
        req     = 4'b0000;
        data_in = '0;
        for (int i = 0; i < 4; i++) begin
            d[i] = sprite_word(3'd1, 10'(10 * i + 1), 10'(20 * i + 2), 9'(i + 3));
            data_in[32*i +: 32] = d[i];
        end
        step();
        step();
        reset = 1'b0;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr",  32'(wr_addr), 32'd0);
        chk("rst_data",  wr_data, 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);

        // No vblank: requests are ignored.
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("novb_grant", 32'(grant), 32'd0);
            chk("novb_wr_en", 32'(wr_en), 32'd0);
            chk("novb_busy",  32'(busy), 32'd0);
        end

        // Round-robin from requester 0, one grant every other cycle.
        vblank = 1'b1;
        step();
        chk("rr_scan_busy",  32'(busy), 32'd1);
        chk("rr_scan_grant", 32'(grant), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_grant",   32'(grant), 32'(4'b0001 << i));
            chk("rr_wr_en",   32'(wr_en), 32'd1);
            chk("rr_addr",    32'(wr_addr), 32'(i));
            chk("rr_data",    wr_data, d[i]);
            chk("wrap_addr",  32'(wr_addr_w), 32'((30 + i) % 32));
            req[i] = 1'b0;
            step();
            chk("rr_gap_grant", 32'(grant), 32'd0);
            chk("rr_gap_wr_en", 32'(wr_en), 32'd0);
        end
        chk("wrap_req3_addr", 32'(wr_addr_w), 32'd1);

        // Duplicate word for requester 2: second grant has no write.
        data_in[64 +: 32] = 32'h20A05000;
        req = 4'b0100;
        step();
        chk("dup1_grant", 32'(grant), 32'h4);
        chk("dup1_wr_en", 32'(wr_en), 32'd1);
        chk("dup1_data",  wr_data, 32'h20A05000);
        req = 4'b0000;
        step();
        req = 4'b0100;
        step();
        chk("dup2_grant", 32'(grant), 32'h4);
        chk("dup2_wr_en", 32'(wr_en), 32'd0);
        req = 4'b0000;
        step();

        // vblank falls during requester 1's write.
        data_in[32 +: 32] = 32'hABCD0001;
        req = 4'b0010;
        step();
        chk("vbf_grant", 32'(grant), 32'h2);
        chk("vbf_wr_en", 32'(wr_en), 32'd1);
        chk("vbf_addr",  32'(wr_addr), 32'd1);
        vblank = 1'b0;
        req    = 4'b0000;
        step();
        chk("vbf_scan_busy",  32'(busy), 32'd1);
        chk("vbf_scan_wr_en", 32'(wr_en), 32'd0);
        step();
        chk("vbf_idle_busy",  32'(busy), 32'd0);

        // Reset during a write clears outputs and shadow state.
        data_in[96 +: 32] = 32'h33330003;
        vblank = 1'b1;
        req    = 4'b1000;
        step();
        chk("rw_scan_busy", 32'(busy), 32'd1);
        step();
        chk("rw_grant", 32'(grant), 32'h8);
        chk("rw_wr_en", 32'(wr_en), 32'd1);
        chk("rw_addr",  32'(wr_addr), 32'd3);
        reset = 1'b1;
        req   = 4'b0000;
        step();
        reset = 1'b0;
        chk("rw_post_grant", 32'(grant), 32'd0);
        chk("rw_post_wr_en", 32'(wr_en), 32'd0);
        chk("rw_post_busy",  32'(busy), 32'd0);
        chk("rw_post_addr",  32'(wr_addr), 32'd0);
        chk("rw_post_data",  wr_data, 32'd0);
        req = 4'b1000;
        step();
        chk("rw_again_scan", 32'(busy), 32'd1);
        step();
        chk("rw_again_grant", 32'(grant), 32'h8);
        chk("rw_again_wr_en", 32'(wr_en), 32'd1);
        chk("rw_again_data",  wr_data, 32'h33330003);
        req = 4'b0000;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sprite_write_arbiter.md
SPRITE_WRITE_ARBITER -- requirements
Module: sprite_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of sprite-word requesters (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 5: sprite register-bank address width.
REQ-003 The block SHALL have parameter SLOT_BASE, default 0: bank address of requester 0; requester i writes SLOT_BASE+i.
REQ-004 The block SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port vblank, input, 1: level; high while the video generator is in vertical blanking.
REQ-007 The block SHALL have port req, input, NUM_REQ: per-requester write request, level, held until granted.
REQ-008 The block SHALL have port data_in, input, NUM_REQ*32: flattened sprite words; requester i at [32i+31:32i]; format [31:29] sprite/active, [28:19] x, [18:9] y, [8:0] offset.
REQ-009 The block SHALL have port grant, output, NUM_REQ: one-hot, one-cycle acknowledge.
REQ-010 The block SHALL have port wr_en, output, 1: register-bank write strobe.
REQ-011 The block SHALL have port wr_addr, output, ADDR_W: register-bank write address.
REQ-012 The block SHALL have port wr_data, output, 32: register-bank write data.
REQ-013 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SCAN, WRITE.
REQ-015 IDLE -> SCAN when vblank=1; otherwise stay in IDLE; no grants are issued in IDLE.
REQ-016 SCAN with vblank=0 -> IDLE.
REQ-017 SCAN with vblank=1 and req=0 -> stay in SCAN.
REQ-018 SCAN with vblank=1 and any req bit set -> select winner round-robin, searching from last_winner+1 modulo NUM_REQ; register wr_data<=data_in[winner], wr_addr<=SLOT_BASE+winner; update last_winner; go to WRITE.
REQ-019 In WRITE, grant[winner]=1 for exactly that cycle; all other grant bits SHALL be 0.
REQ-020 In WRITE, wr_en SHALL be 1 unless the skip rule (REQ-022) applies.
REQ-021 WRITE SHALL last one cycle and exit unconditionally to SCAN; a vblank fall during WRITE does not abort the write, and the FSM then reaches IDLE via SCAN.
REQ-022 Each requester SHALL have a 32-bit shadow register and a valid bit; if valid and shadow equals the captured word, grant SHALL still pulse but wr_en SHALL stay 0.
REQ-023 On every WRITE with wr_en=1, shadow[winner] SHALL be updated to wr_data and valid[winner] set to 1.
REQ-024 Throughput SHALL be at most one grant per 2 cycles; latency from req sampled in SCAN to grant/wr_en SHALL be 1 cycle.
REQ-025 Requesters SHALL deassert req in the cycle after grant; a req still high after grant is treated as a new request.
REQ-026 A requester dropping req before grant SHALL be treated as withdrawn; no write for it occurs.
REQ-027 wr_addr SHALL be SLOT_BASE+winner, truncated to ADDR_W bits.

Reset
REQ-028 When reset=1 at a clock edge: state IDLE; grant=0; wr_en=0; wr_addr=0; wr_data=0; busy=0; last_winner=NUM_REQ-1, so requester 0 has first priority; all shadow valid bits 0.
REQ-029 Reset asserted mid-WRITE SHALL take priority: no wr_en or grant in the following cycle.

Structure
REQ-030 Sprite word field positions (ACTIVE [31:29], X [28:19], Y [18:9], OFFSET [8:0]) and the FSM state encoding SHALL live in the shared sprite package.
REQ-031 The round-robin selector SHALL be a sub-module rr_select (inputs: req, last; outputs: winner index, any); all else in the top module.

Verification
REQ-032 Directed scenario, vblank=0, req=4'b1111 for 20 cycles -> grant=0, wr_en=0, busy=0 throughout.
REQ-033 Directed scenario, after reset, vblank=1, req=4'b1111 held (deassert on grant) -> grants in order 0,1,2,3 on alternate cycles; wr_addr 0,1,2,3.
REQ-034 Directed scenario, requester 2 data=32'h2_0A_05_000 written, then same word requested again -> second grant[2] pulses with wr_en=0.
REQ-035 Directed scenario, requester 1 granted, then vblank falls in its WRITE cycle -> wr_en=1 for addr 1, then SCAN, then IDLE; busy falls 2 cycles after WRITE.
REQ-036 Directed scenario, reset pulsed in WRITE cycle -> next cycle wr_en=0, grant=0, state IDLE; re-sending the same word afterwards produces wr_en=1 (shadow cleared).
REQ-037 Directed scenario, NUM_REQ=4, SLOT_BASE=30, ADDR_W=5 -> requester 3 writes address 1 (wrap).
